ahb_matrix_rr_arbiter: RTL and testbench

- Output-stage arbiter for the AHB bus matrix. Chooses which of NUM_PORTS input stages drives one shared output (slave-side) port.
- Round-robin between ports. A grant is held through bursts and locked sequences.
- Produces address-phase and data-phase port selects for the output-stage muxes.
- When no port requests, flags no_port so the output stage drives an IDLE transfer. The default slave then handles unmapped traffic.

---
 rtl/ahb_matrix_pkg.sv | 27 ++
 rtl/ahb_matrix_rr_arbiter_rr_picker.sv | 41 ++++
 rtl/ahb_matrix_rr_arbiter.sv | 101 ++++++++++
 tb/tb_ahb_matrix_rr_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_matrix_pkg.sv
// Shared definitions for the AHB bus matrix: transfer/response encodings
// and the port-index width helper used by the arbiters.
package ahb_matrix_pkg;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RSP_OKAY  = 2'b00,
    RSP_ERROR = 2'b01,
    RSP_RETRY = 2'b10,
    RSP_SPLIT = 2'b11
  } hresp_e;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 8;

  // Never narrower than one bit, so a two-port matrix still has an index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_matrix_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after
// last_grant, found by masking a doubled request vector.
module rr_picker
  import ahb_matrix_pkg::*;
#(
  parameter  int NUM_PORTS = 3,
  localparam int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_req
);

  logic [2*NUM_PORTS-1:0] dbl_req;
  logic [2*NUM_PORTS-1:0] mask;
  logic [2*NUM_PORTS-1:0] masked;

  assign dbl_req = {req, req};

  // Positions at or below last_grant are masked off; the upper copy brings
  // the wrapped-around ports (including last_grant itself) in last.
  generate
    for (genvar gi = 0; gi < 2*NUM_PORTS; gi++) begin : g_mask
      assign mask[gi] = (gi > int'(last_grant));
    end
  endgenerate

  assign masked  = dbl_req & mask;
  assign any_req = |req;

  always_comb begin
    winner = '0;
    for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
      if (masked[i]) begin
        winner = IDX_W'((i >= NUM_PORTS) ? (i - NUM_PORTS) : i);
      end
    end
  end

endmodule

// File: rtl/ahb_matrix_rr_arbiter.sv
// Output-stage round-robin arbiter for the AHB bus matrix; holds grants
// across bursts. Define AHB_ARB_LOCK_EN to also hold on HMASTLOCK.
module ahb_matrix_rr_arbiter
  import ahb_matrix_pkg::*;
#(
  parameter  int NUM_PORTS = 3,
  localparam int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_PORTS-1:0]   req_port,
  input  logic [2*NUM_PORTS-1:0] htrans_port,
  input  logic [NUM_PORTS-1:0]   hmastlock_port,
  input  logic                   HREADYM,
  output logic [IDX_W-1:0]       addr_in_port,
  output logic [IDX_W-1:0]       data_in_port,
  output logic                   no_port,
  output logic                   data_valid
);

  generate
    if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_param
      $error("ahb_matrix_rr_arbiter: NUM_PORTS out of range 2..8");
    end
  endgenerate

  logic [1:0]       trn [NUM_PORTS];
  logic [1:0]       owner_trn;
  logic             owner_lock;
  logic             hold;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [IDX_W-1:0] last_grant_reg;
  logic [IDX_W-1:0] last_grant_next;
  logic [IDX_W-1:0] addr_next;
  logic             no_port_next;
  logic             data_valid_next;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_trn
      assign trn[gi] = htrans_port[2*gi +: 2];
    end
  endgenerate

  assign owner_trn = trn[addr_in_port];

`ifdef AHB_ARB_LOCK_EN
  assign owner_lock = hmastlock_port[addr_in_port];
`else
  logic unused_lock;
  assign owner_lock  = 1'b0;
  assign unused_lock = ^hmastlock_port;
`endif

  // A live owner keeps the bus through SEQ/BUSY beats (and lock, if enabled).
  assign hold = ~no_port & ((owner_trn == TRN_SEQ) | (owner_trn == TRN_BUSY) | owner_lock);

  rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req        (req_port),
    .last_grant (last_grant_reg),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    addr_next       = addr_in_port;
    no_port_next    = no_port;
    last_grant_next = last_grant_reg;
    if (!hold) begin
      if (any_req) begin
        addr_next       = winner;
        no_port_next    = 1'b0;
        last_grant_next = winner;
      end else begin
        no_port_next = 1'b1;
      end
    end
  end

  // Only NONSEQ/SEQ carry data; the MSB of HTRANS separates them from IDLE/BUSY.
  assign data_valid_next = ~no_port & owner_trn[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port   <= '0;
      data_in_port   <= '0;
      no_port        <= 1'b1;
      data_valid     <= 1'b0;
      last_grant_reg <= IDX_W'(NUM_PORTS-1);
    end else if (HREADYM) begin
      addr_in_port   <= addr_next;
      data_in_port   <= addr_in_port;
      no_port        <= no_port_next;
      data_valid     <= data_valid_next;
      last_grant_reg <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_ahb_matrix_rr_arbiter.sv
// Scoreboard bench for ahb_matrix_rr_arbiter: directed scenarios then
// random traffic, checked against a rule-level round-robin model.
module tb_ahb_matrix_rr_arbiter;

  localparam int N = 3;
  localparam int W = 2;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b0;
  logic [N-1:0]   req_port = '0;
  logic [2*N-1:0] htrans_port = '0;
  logic [N-1:0]   hmastlock_port = '0;
  logic           HREADYM = 1'b1;
  logic [W-1:0]   addr_in_port;
  logic [W-1:0]   data_in_port;
  logic           no_port;
  logic           data_valid;

  ahb_matrix_rr_arbiter #(.NUM_PORTS(N)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .req_port       (req_port),
    .htrans_port    (htrans_port),
    .hmastlock_port (hmastlock_port),
    .HREADYM        (HREADYM),
    .addr_in_port   (addr_in_port),
    .data_in_port   (data_in_port),
    .no_port        (no_port),
    .data_valid     (data_valid)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int data;
    bit np;
    bit dv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference state: who owns the address phase, data phase, last winner.
  int m_addr, m_data, m_last;
  bit m_np, m_dv;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_data = 0; m_np = 1'b1; m_dv = 1'b0; m_last = N-1;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [2*N-1:0] t,
                            input logic [N-1:0] l, input logic rdy);
    int  ot, win;
    bit  held, found, lk;
    if (!rdy) return;
    ot = (int'(t) >> (2*m_addr)) & 3;
`ifdef AHB_ARB_LOCK_EN
    lk = l[m_addr];
`else
    lk = 1'b0;
`endif
    held = !m_np && (ot == 3 || ot == 1 || lk);
    m_dv   = !m_np && (ot >= 2);
    m_data = m_addr;
    if (!held) begin
      found = 1'b0;
      win = 0;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (r[p] && !found) begin
          found = 1'b1;
          win = p;
        end
      end
      if (found) begin
        m_addr = win; m_np = 1'b0; m_last = win;
      end else begin
        m_np = 1'b1;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.cyc = cyc + 1; e.addr = m_addr; e.data = m_data; e.np = m_np; e.dv = m_dv;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r, input logic [2*N-1:0] t,
                      input logic [N-1:0] l, input logic rdy);
    req_port = r; htrans_port = t; hmastlock_port = l; HREADYM = rdy;
    model_edge(r, t, l, rdy);
    push_expected();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("async_rst_no_port", 8'(no_port), 8'd1);
    check("async_rst_valid", 8'(data_valid), 8'd0);
    check("async_rst_addr", 8'(addr_in_port), 8'd0);
    model_reset();
    push_expected();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  // Monitor: compares whatever the scoreboard expects for this edge.
  initial begin
    forever begin
      @(posedge HCLK);
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc == cyc) begin
          check("addr_in_port", 8'(addr_in_port), 8'(mon_e.addr));
          check("data_in_port", 8'(data_in_port), 8'(mon_e.data));
          check("no_port", 8'(no_port), 8'(mon_e.np));
          check("data_valid", 8'(data_valid), 8'(mon_e.dv));
          $display("cyc %0d: addr=%0d data=%0d no_port=%0b valid=%0b", cyc,
                   addr_in_port, data_in_port, no_port, data_valid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0]   rr, ll;
    logic [2*N-1:0] tt;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_no_port", 8'(no_port), 8'd1);
    check("rst_addr", 8'(addr_in_port), 8'd0);
    check("rst_data", 8'(data_in_port), 8'd0);
    check("rst_valid", 8'(data_valid), 8'd0);
    HRESETn = 1'b1;

    repeat (2) step(3'b000, 6'b000000, 3'b000, 1'b1);

    // Everyone requesting single NONSEQ transfers: plain rotation.
    repeat (6) step(3'b111, 6'b101010, 3'b000, 1'b1);

    // Port 1 burst with a three-cycle wait state in the middle.
    for (int i = 0; i < 8 && !(m_addr == 1 && !m_np); i++)
      step(3'b111, 6'b101010, 3'b000, 1'b1);
    step(3'b111, 6'b101110, 3'b000, 1'b1);
    repeat (3) step(3'b001, 6'b101110, 3'b000, 1'b0);
    repeat (2) step(3'b111, 6'b101110, 3'b000, 1'b1);
    step(3'b101, 6'b100010, 3'b000, 1'b1);
    step(3'b101, 6'b100010, 3'b000, 1'b1);

    // Lone requester is re-granted every cycle.
    repeat (4) step(3'b010, 6'b001000, 3'b000, 1'b1);

    // Locked sequence from port 2 containing an IDLE beat.
    for (int i = 0; i < 8 && !(m_addr == 2 && !m_np); i++)
      step(3'b100, 6'b100000, 3'b000, 1'b1);
    step(3'b101, 6'b100010, 3'b100, 1'b1);
    step(3'b101, 6'b000010, 3'b100, 1'b1);
    step(3'b101, 6'b100010, 3'b100, 1'b1);
    step(3'b101, 6'b100010, 3'b000, 1'b1);
    step(3'b001, 6'b000010, 3'b000, 1'b1);

    // Reset in the middle of a port 1 SEQ beat.
    for (int i = 0; i < 8 && !(m_addr == 1 && !m_np); i++)
      step(3'b010, 6'b001000, 3'b000, 1'b1);
    step(3'b010, 6'b001100, 3'b000, 1'b1);
    do_reset();
    repeat (3) step(3'b111, 6'b101010, 3'b000, 1'b1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rr = N'($urandom);
      tt = (2*N)'($urandom);
      ll = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step(rr, tt, ll, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge HCLK);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
